// File: rtl/pe_conv_stream.sv
// pe_conv_stream: KxK signed convolution over a streamed activation tile.
//
// K rows of cfg_row_len (L) activations produce one output row of L-K+1 psums.
// Weights are loaded one kernel row at a time while IDLE. Activations arrive on
// a valid/ready stream. Finished psums leave through a first-word-fall-through
// sync FIFO with valid/ready.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start, abort        start a tile (latches cfg_*), flush back to IDLE
//   cfg_row_len         activations per row, legal range K..MAX_LEN
//   cfg_relu            clamp negative outputs to zero
//   wgt_we/row/data     kernel row write (IDLE only), tap t at [t*WGT_W +: WGT_W]
//   act_valid/ready/data  activation stream
//   out_valid/ready/data  psum stream from the FIFO head
//   busy, done, cfg_err   status: running, end-of-tile pulse, sticky bad config
module pe_conv_stream #(
    parameter int ACT_W      = 8,
    parameter int WGT_W      = 8,
    parameter int K          = 3,
    parameter int MAX_LEN    = 64,
    parameter int PSUM_W     = 24,
    parameter int FIFO_DEPTH = 4,
    localparam int LEN_W     = $clog2(MAX_LEN + 1),
    localparam int ROW_W     = (K > 1) ? $clog2(K) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [LEN_W-1:0]   cfg_row_len,
    input  logic               cfg_relu,
    input  logic               wgt_we,
    input  logic [ROW_W-1:0]   wgt_row,
    input  logic [K*WGT_W-1:0] wgt_data,
    input  logic               act_valid,
    output logic               act_ready,
    input  logic [ACT_W-1:0]   act_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PSUM_W-1:0]  out_data,
    output logic               busy,
    output logic               done,
    output logic               cfg_err
);

    localparam int WIN_N  = (K > 1) ? K - 1 : 1;
    localparam int ACC_N  = MAX_LEN - K + 1;
    localparam int ACC_AW = (ACC_N > 1) ? $clog2(ACC_N) : 1;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int PROD_W = ACT_W + WGT_W;

    typedef enum logic [0:0] {S_IDLE, S_RUN} state_t;

    function automatic logic signed [PSUM_W-1:0] relu_clamp(
        input logic signed [PSUM_W-1:0] v,
        input logic                     en
    );
        return (en && v[PSUM_W-1]) ? '0 : v;
    endfunction

    state_t                    state_q, state_d;
    logic [LEN_W-1:0]          len_q, len_d;
    logic                      relu_q, relu_d;
    logic                      cfg_err_q, cfg_err_d;
    logic                      done_q, done_d;
    logic [LEN_W-1:0]          col_q, col_d;
    logic [ROW_W-1:0]          row_q, row_d;
    logic signed [WGT_W-1:0]   wgt_q [K][K];
    logic signed [WGT_W-1:0]   wgt_d [K][K];
    // Last K-1 activations of the current row, index WIN_N-1 is the newest.
    logic signed [ACT_W-1:0]   win_q [WIN_N];
    logic signed [ACT_W-1:0]   win_d [WIN_N];
    logic signed [PSUM_W-1:0]  acc_q [ACC_N];
    logic signed [PSUM_W-1:0]  acc_d [ACC_N];
    logic signed [PSUM_W-1:0]  mem_q [FIFO_DEPTH];
    logic signed [PSUM_W-1:0]  mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;

    logic signed [ACT_W-1:0]   tap  [K];
    logic signed [PROD_W-1:0]  prod [K];
    logic signed [PSUM_W-1:0]  dot;
    logic signed [PSUM_W-1:0]  base;
    logic signed [PSUM_W-1:0]  sum;
    logic [ACC_AW-1:0]         acc_idx;
    logic                      last_row, last_col, has_dot;
    logic                      fifo_full, pop, push, accept;

    assign last_row  = (row_q == ROW_W'(K - 1));
    assign last_col  = (col_q == len_q - LEN_W'(1));
    assign has_dot   = (col_q >= LEN_W'(K - 1));
    assign fifo_full = (cnt_q == CNT_W'(FIFO_DEPTH));
    assign out_valid = (cnt_q != '0);
    assign pop       = out_valid && out_ready;
    // A full FIFO only blocks the last row, and only if no pop frees a slot now.
    assign act_ready = (state_q == S_RUN) && !(last_row && fifo_full && !pop);
    assign accept    = act_valid && act_ready && !abort;
    assign push      = accept && has_dot && last_row;
    assign acc_idx   = ACC_AW'(col_q - LEN_W'(K - 1));
    assign out_data  = mem_q[rd_ptr_q];
    assign busy      = (state_q == S_RUN);
    assign done      = done_q;
    assign cfg_err   = cfg_err_q;

    // Window taps: oldest K-1 from the shift register, newest is the live input.
    always_comb begin
        for (int t = 0; t < K; t++) begin
            tap[t] = '0;
        end
        for (int t = 0; t < K - 1; t++) begin
            tap[t] = win_q[t];
        end
        tap[K-1] = act_data;
    end

    always_comb begin
        dot = '0;
        for (int t = 0; t < K; t++) begin
            prod[t] = PROD_W'(wgt_q[row_q][t]) * PROD_W'(tap[t]);
            dot     = dot + PSUM_W'(prod[t]);
        end
    end

    // Row 0 starts a fresh partial sum; later rows add onto the stored one.
    assign base = (row_q == '0) ? '0 : acc_q[acc_idx];
    assign sum  = base + dot;

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        relu_d    = relu_q;
        cfg_err_d = cfg_err_q;
        done_d    = 1'b0;
        col_d     = col_q;
        row_d     = row_q;
        wgt_d     = wgt_q;
        win_d     = win_q;
        acc_d     = acc_q;
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (wgt_we && (int'(wgt_row) < K)) begin
                    for (int t = 0; t < K; t++) begin
                        wgt_d[wgt_row][t] = wgt_data[t*WGT_W +: WGT_W];
                    end
                end
                if (start) begin
                    if ((cfg_row_len >= LEN_W'(K)) && (cfg_row_len <= LEN_W'(MAX_LEN))) begin
                        state_d   = S_RUN;
                        len_d     = cfg_row_len;
                        relu_d    = cfg_relu;
                        cfg_err_d = 1'b0;
                        col_d     = '0;
                        row_d     = '0;
                        win_d     = '{default: '0};
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (accept) begin
                    if (has_dot) begin
                        if (last_row) begin
                            mem_d[wr_ptr_q] = relu_clamp(sum, relu_q);
                            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
                        end else begin
                            acc_d[acc_idx] = sum;
                        end
                    end
                    if (last_col) begin
                        col_d = '0;
                        win_d = '{default: '0};
                        if (last_row) begin
                            row_d   = '0;
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            row_d = row_q + ROW_W'(1);
                        end
                    end else begin
                        col_d = col_q + LEN_W'(1);
                        for (int i = 0; i < WIN_N - 1; i++) begin
                            win_d[i] = win_q[i+1];
                        end
                        win_d[WIN_N-1] = act_data;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase

        // Abort overrides everything above, including a same-cycle start.
        if (abort) begin
            state_d   = S_IDLE;
            cfg_err_d = cfg_err_q;
            done_d    = 1'b0;
            col_d     = '0;
            row_d     = '0;
            win_d     = '{default: '0};
            acc_d     = '{default: '0};
            mem_d     = '{default: '0};
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            cnt_d     = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            len_q     <= '0;
            relu_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            done_q    <= 1'b0;
            col_q     <= '0;
            row_q     <= '0;
            wgt_q     <= '{default: '{default: '0}};
            win_q     <= '{default: '0};
            acc_q     <= '{default: '0};
            mem_q     <= '{default: '0};
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            relu_q    <= relu_d;
            cfg_err_q <= cfg_err_d;
            done_q    <= done_d;
            col_q     <= col_d;
            row_q     <= row_d;
            wgt_q     <= wgt_d;
            win_q     <= win_d;
            acc_q     <= acc_d;
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule
